mfp_adc_max10_responder: RTL and testbench
==========================================

// Module: mfp_adc_max10_responder
// PURPOSE
//   Synthesizable stand-in for the MAX10 modular ADC sequencer's command/response Avalon-ST
//   endpoints. It accepts conversion commands from mfp_adc_max10_core and returns one 12-bit
//   result per command after a fixed conversion latency. Used in benches and in FPGA builds
//   without the ADC IP, so the core can be exercised with deterministic, checkable data.
// PARAMETERS
//   CONV_CYCLES  5   CLK cycles between command acceptance and response; legal range >= 1
//   CH_COUNT     17  number of valid channels (0..CH_COUNT-1); higher channels return zero data
//   SEQ_WIDTH    7   width of the sample sequence counter that is embedded in the data
// PORTS
//   CLK                     in   1   system clock, all logic on rising edge
//   RESETn                  in   1   asynchronous active-low reset
//   adc_pll_locked          in   1   converter clock locked; when 0, no commands are accepted
//   command_valid           in   1   command present
//   command_channel         in   5   channel to convert
//   command_startofpacket   in   1   SOP tag, returned on the response
//   command_endofpacket     in   1   EOP tag, returned on the response
//   command_ready           out  1   responder can accept a command this cycle
//   response_valid          out  1   one-cycle result strobe (no backpressure)
//   response_channel        out  5   channel of the result
//   response_data           out  12  conversion result
//   response_startofpacket  out  1   latched SOP tag of the command
//   response_endofpacket    out  1   latched EOP tag of the command
// BEHAVIOUR
//   - Reset: state=IDLE, all outputs 0, cnt=0, seq=0, latched channel/SOP/EOP = 0.
//   - FSM states IDLE, CONV, RESP; command_ready = adc_pll_locked & (state==IDLE | state==RESP).
//   - Accept condition: command_valid & command_ready at rising edge k. At that edge the
//     block latches channel, SOP and EOP, sets cnt=CONV_CYCLES-1 and moves to CONV.
//   - CONV: when cnt!=0, decrement cnt; when cnt==0, move to RESP. CONV lasts CONV_CYCLES cycles.
//   - RESP is entered at edge k+CONV_CYCLES. response_valid=1 for exactly one cycle. Response
//     fields hold their values until the next response, but are valid only while response_valid=1.
//   - Data: channel<CH_COUNT -> response_data = {channel[4:0], seq[6:0]} (SEQ_WIDTH=7).
//     channel>=CH_COUNT -> response_data = 12'h000. In both cases seq is incremented.
//   - seq increments by 1 on every RESP cycle, modulo 2^SEQ_WIDTH (127 wraps to 0).
//   - RESP -> CONV when a command is accepted in the RESP cycle (back-to-back operation;
//     minimum command period is CONV_CYCLES+1). Otherwise RESP -> IDLE.
//   - command_valid while ready=0 is ignored. The initiator must hold the command; no queueing.
//   - adc_pll_locked falls during CONV: abort to IDLE with no response; seq unchanged.
//     adc_pll_locked falls during RESP: the response still completes.
//   - RESETn asserted mid-operation: immediate return to reset values; the pending response is lost.
//   - Channel width arithmetic: a channel field of 5 bits is compared unsigned against CH_COUNT.
// TESTING
//   1 locked=1, cmd ch=3 SOP=1 EOP=1 accepted at edge k -> response_valid only in the cycle
//     after edge k+5; ch=3, data=12'h180, SOP=EOP=1; command_ready=0 during cycles k+1..k+5.
//   2 valid held high with ch=1 for 4 commands -> accepts every 6 cycles;
//     data=12'h080,081,082,083.
//   3 cmd ch=20 -> response ch=20, data=12'h000; the next ch=0 response carries seq+1.
//   4 locked 1->0 two cycles after accept -> no response_valid, command_ready=0 while
//     locked=0; relock plus a new cmd gives a normal response with seq unchanged.
//   5 130 commands on ch=0 -> data wraps 12'h07F -> 12'h000 at the 129th response.
//   6 RESETn pulsed low mid-CONV -> all outputs 0 immediately; no stale response_valid
//     after release.

Source files
------------

// File: rtl/mfp_adc_max10_responder_if.sv
// Avalon-ST command/response bundle between mfp_adc_max10_core (master) and the
// MAX10 ADC sequencer stand-in (slave).
interface mfp_adc_max10_responder_if;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        response_startofpacket;
    logic        response_endofpacket;

    modport master (
        output command_valid, command_channel, command_startofpacket, command_endofpacket,
        input  command_ready,
        input  response_valid, response_channel, response_data,
        input  response_startofpacket, response_endofpacket
    );

    modport slave (
        input  command_valid, command_channel, command_startofpacket, command_endofpacket,
        output command_ready,
        output response_valid, response_channel, response_data,
        output response_startofpacket, response_endofpacket
    );
endinterface

// File: rtl/mfp_adc_max10_responder.sv
// Deterministic stand-in for the MAX10 modular ADC sequencer: one response per accepted
// command after CONV_CYCLES clocks, data = {channel, sequence count}.
module mfp_adc_max10_responder #(
    parameter int unsigned CONV_CYCLES = 5,
    parameter int unsigned CH_COUNT    = 17,
    parameter int unsigned SEQ_WIDTH   = 7
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic                       adc_pll_locked,
    mfp_adc_max10_responder_if.slave   bus
);

    localparam int unsigned CntW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StConv, StResp} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [SEQ_WIDTH-1:0] seq_q, seq_d;
    logic [4:0]           ch_q, ch_d;
    logic                 sop_q, sop_d;
    logic                 eop_q, eop_d;
    logic [4:0]           rsp_ch_q, rsp_ch_d;
    logic [11:0]          rsp_data_q, rsp_data_d;
    logic                 rsp_sop_q, rsp_sop_d;
    logic                 rsp_eop_q, rsp_eop_d;
    logic                 accept;

    // RESETn gates ready so every output reads 0 while reset is held.
    assign bus.command_ready = RESETn & adc_pll_locked &
                               ((state_q == StIdle) | (state_q == StResp));
    assign accept            = bus.command_valid & bus.command_ready;

    assign bus.response_valid         = (state_q == StResp);
    assign bus.response_channel       = rsp_ch_q;
    assign bus.response_data          = rsp_data_q;
    assign bus.response_startofpacket = rsp_sop_q;
    assign bus.response_endofpacket   = rsp_eop_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        ch_d       = ch_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        rsp_ch_d   = rsp_ch_q;
        rsp_data_d = rsp_data_q;
        rsp_sop_d  = rsp_sop_q;
        rsp_eop_d  = rsp_eop_q;

        if (accept) begin
            ch_d    = bus.command_channel;
            sop_d   = bus.command_startofpacket;
            eop_d   = bus.command_endofpacket;
            cnt_d   = CntW'(CONV_CYCLES - 1);
            state_d = StConv;
        end else begin
            case (state_q)
                StConv: begin
                    if (!adc_pll_locked) begin
                        state_d = StIdle;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        // Response fields are captured here so they stay stable until the
                        // next response even if a new command is accepted meanwhile.
                        state_d    = StResp;
                        rsp_ch_d   = ch_q;
                        rsp_sop_d  = sop_q;
                        rsp_eop_d  = eop_q;
                        rsp_data_d = (32'(ch_q) < CH_COUNT) ? 12'({ch_q, seq_q}) : 12'h000;
                        seq_d      = seq_q + SEQ_WIDTH'(1);
                    end
                end
                StResp:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            seq_q      <= '0;
            ch_q       <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            rsp_ch_q   <= '0;
            rsp_data_q <= '0;
            rsp_sop_q  <= 1'b0;
            rsp_eop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            ch_q       <= ch_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            rsp_ch_q   <= rsp_ch_d;
            rsp_data_q <= rsp_data_d;
            rsp_sop_q  <= rsp_sop_d;
            rsp_eop_q  <= rsp_eop_d;
        end
    end

endmodule

// File: tb/tb_mfp_adc_max10_responder.sv
// Randomised bench for mfp_adc_max10_responder against a count-based reference model.
module tb_mfp_adc_max10_responder;
    localparam int CONV = 5;
    localparam int CHC  = 17;

    logic CLK    = 1'b0;
    logic RESETn = 1'b0;
    logic locked = 1'b0;

    int n_cmp     = 0;
    int n_fail    = 0;
    int seq_model = 0;

    mfp_adc_max10_responder_if bus ();

    mfp_adc_max10_responder #(
        .CONV_CYCLES (CONV),
        .CH_COUNT    (CHC),
        .SEQ_WIDTH   (7)
    ) dut (
        .CLK            (CLK),
        .RESETn         (RESETn),
        .adc_pll_locked (locked),
        .bus            (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected data: channel * 128 + (responses so far mod 128), zero for absent channels.
    function automatic logic [11:0] model_data(input int ch, input int seq);
        if (ch < CHC) return 12'(ch * 128 + (seq % 128));
        return 12'h000;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        bus.command_valid = 1'b0;
        tick();
        tick();
        RESETn = 1'b1;
        seq_model = 0;
        tick();
    endtask

    // Issue one command, check the busy window, the response and the single-cycle strobe.
    task automatic issue(input logic [4:0] ch, input logic sop, input logic eop,
                         input string name, output logic [11:0] got);
        int waited;
        bit ok;
        logic [11:0] exp_d;
        bus.command_valid         = 1'b1;
        bus.command_channel       = ch;
        bus.command_startofpacket = sop;
        bus.command_endofpacket   = eop;
        waited = 0;
        ok = 0;
        got = '0;
        while (!ok && waited < 20) begin
            @(negedge CLK);
            if (bus.command_ready === 1'b1) ok = 1;
            else begin
                tick();
                waited++;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s accept: command_ready stayed 0 for 20 cycles, required 1", name);
            bus.command_valid = 1'b0;
            return;
        end
        tick();
        bus.command_valid = 1'b0;
        for (int i = 1; i <= CONV; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (bus.command_ready !== 1'b0 || bus.response_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: ready=%b resp_valid=%b, required 0/0",
                         name, i, bus.command_ready, bus.response_valid);
            end
            tick();
        end
        @(negedge CLK);
        exp_d = model_data(int'(ch), seq_model);
        got = bus.response_data;
        n_cmp++;
        if ({bus.response_valid, bus.response_channel, bus.response_data,
             bus.response_startofpacket, bus.response_endofpacket} !==
            {1'b1, ch, exp_d, sop, eop}) begin
            n_fail++;
            $display("FAIL %s response: valid=%b ch=%0d data=%h sop=%b eop=%b, required 1 %0d %h %b %b",
                     name, bus.response_valid, bus.response_channel, bus.response_data,
                     bus.response_startofpacket, bus.response_endofpacket, ch, exp_d, sop, eop);
        end
        seq_model++;
        tick();
        @(negedge CLK);
        n_cmp++;
        if (bus.response_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s strobe width: response_valid=%b one cycle later, required 0",
                     name, bus.response_valid);
        end
        tick();
    endtask

    task automatic test_reset();
        locked = 1'b1;
        RESETn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.command_ready, bus.response_valid, bus.response_channel, bus.response_data,
             bus.response_startofpacket, bus.response_endofpacket} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset outputs: ready=%b valid=%b ch=%0d data=%h, required all 0",
                     bus.command_ready, bus.response_valid, bus.response_channel,
                     bus.response_data);
        end
        tick();
        RESETn = 1'b1;
        seq_model = 0;
        @(negedge CLK);
        n_cmp++;
        if (bus.command_ready !== 1'b1 || bus.response_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset release: ready=%b valid=%b, required 1/0",
                     bus.command_ready, bus.response_valid);
        end
        tick();
    endtask

    task automatic test_single();
        logic [11:0] got;
        issue(5'd3, 1'b1, 1'b1, "single", got);
        n_cmp++;
        if (got !== 12'h180) begin
            n_fail++;
            $display("FAIL single data: got %h, required 180", got);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int nresp = 0;
        int first = -1;
        int rcyc[4];
        logic [11:0] rdat[4];
        bus.command_valid         = 1'b1;
        bus.command_channel       = 5'd1;
        bus.command_startofpacket = 1'b0;
        bus.command_endofpacket   = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge CLK);
            if (bus.response_valid === 1'b1 && nresp < 4) begin
                rcyc[nresp] = cyc;
                rdat[nresp] = bus.response_data;
                nresp++;
            end
            if (bus.command_ready === 1'b1 && bus.command_valid === 1'b1) begin
                if (acc == 0) first = cyc;
                acc++;
            end
            tick();
            if (acc == 4) bus.command_valid = 1'b0;
        end
        n_cmp++;
        if (nresp != 4 || first != 0) begin
            n_fail++;
            $display("FAIL b2b count: responses=%0d first_accept=%0d, required 4 and 0",
                     nresp, first);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rcyc[i] != first + (CONV + 1) * (i + 1) ||
                    rdat[i] !== model_data(1, seq_model + i)) begin
                    n_fail++;
                    $display("FAIL b2b resp %0d: cycle=%0d data=%h, required %0d %h", i,
                             rcyc[i], rdat[i], first + (CONV + 1) * (i + 1),
                             model_data(1, seq_model + i));
                end
            end
        end
        seq_model += nresp;
    endtask

    task automatic test_out_of_range();
        logic [11:0] got;
        issue(5'd20, 1'b0, 1'b1, "ch20", got);
        n_cmp++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL ch20 data: got %h, required 000", got);
        end
        issue(5'd16, 1'b1, 1'b0, "ch16", got);
        issue(5'd17, 1'b0, 1'b0, "ch17", got);
        issue(5'd0, 1'b1, 1'b0, "ch0 after oor", got);
    endtask

    task automatic test_pll_abort();
        logic [11:0] got;
        bus.command_valid   = 1'b1;
        bus.command_channel = 5'd5;
        @(negedge CLK);
        n_cmp++;
        if (bus.command_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pll pre-accept: ready=%b, required 1", bus.command_ready);
        end
        tick();
        bus.command_valid = 1'b0;
        tick();
        tick();
        locked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bus.command_valid = 1'b1;
            @(negedge CLK);
            n_cmp++;
            if (bus.command_ready !== 1'b0 || bus.response_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL pll unlocked cycle %0d: ready=%b valid=%b, required 0/0",
                         i, bus.command_ready, bus.response_valid);
            end
            tick();
        end
        bus.command_valid = 1'b0;
        locked = 1'b1;
        tick();
        issue(5'd2, 1'b0, 1'b1, "pll relock", got);
    endtask

    task automatic test_seq_wrap();
        logic [11:0] got;
        do_reset();
        for (int n = 0; n < 130; n++) begin
            issue(5'd0, 1'b0, 1'b0, "wrap", got);
            if (n == 127) begin
                n_cmp++;
                if (got !== 12'h07F) begin
                    n_fail++;
                    $display("FAIL wrap 128th: got %h, required 07F", got);
                end
            end
            if (n == 128) begin
                n_cmp++;
                if (got !== 12'h000) begin
                    n_fail++;
                    $display("FAIL wrap 129th: got %h, required 000", got);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.command_valid         = 1'b1;
        bus.command_channel       = 5'd7;
        bus.command_startofpacket = 1'b1;
        bus.command_endofpacket   = 1'b1;
        @(negedge CLK);
        tick();
        bus.command_valid = 1'b0;
        tick();
        tick();
        RESETn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.command_ready, bus.response_valid, bus.response_channel, bus.response_data,
             bus.response_startofpacket, bus.response_endofpacket} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset mid outputs: ready=%b valid=%b ch=%0d data=%h sop=%b eop=%b, required all 0",
                     bus.command_ready, bus.response_valid, bus.response_channel,
                     bus.response_data, bus.response_startofpacket, bus.response_endofpacket);
        end
        tick();
        RESETn = 1'b1;
        seq_model = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (bus.response_valid !== 1'b0 || bus.command_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset mid stale cycle %0d: valid=%b ready=%b, required 0/1",
                         i, bus.response_valid, bus.command_ready);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [11:0] got;
        logic [4:0] ch;
        logic sop;
        logic eop;
        for (int n = 0; n < 25; n++) begin
            ch  = 5'($urandom_range(0, 31));
            sop = 1'($urandom_range(0, 1));
            eop = 1'($urandom_range(0, 1));
            issue(ch, sop, eop, "random", got);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        bus.command_valid         = 1'b0;
        bus.command_channel       = 5'd0;
        bus.command_startofpacket = 1'b0;
        bus.command_endofpacket   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_range();
        test_pll_abort();
        test_seq_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
